// File: rtl/sipo_deser_if.sv
// Serial input / parallel output handshake bundle for sipo_deser.
// The slave modport is the deserializer side; master is the stream source and word consumer.
interface sipo_deser_if #(
    parameter int WIDTH = 7
);
    logic             si;
    logic             si_valid;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             o_ready;
    logic             busy;
    logic             overrun;
    logic             perr;

    modport master (
        output si, si_valid, o_ready,
        input  o, o_valid, busy, overrun, perr
    );

    modport slave (
        input  si, si_valid, o_ready,
        output o, o_valid, busy, overrun, perr
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-word valid/ready output buffer.
// Optional even parity per word is enabled with the macro SIPO_DESER_PARITY_EN.
module sipo_deser #(
    parameter int WIDTH     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    sipo_deser_if.slave bus
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] word_d;
    logic             o_valid_q, o_valid_d;
    logic             busy_q;
    logic             overrun_q, overrun_d;
    logic             last;
    logic             slot_free;
`ifdef SIPO_DESER_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
        if (MSB_FIRST) return {w[WIDTH-2:0], b};
        else           return {b, w[WIDTH-1:1]};
    endfunction

    assign last      = bus.si_valid && (cnt_q == CNT_W'(N - 1));
    assign slot_free = !o_valid_q || bus.o_ready;

    // With parity the final bit is the parity bit, so the word is already complete in the shifter.
`ifdef SIPO_DESER_PARITY_EN
    assign word_d = shf_q;
`else
    assign word_d = shift_in(shf_q, bus.si);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shf_d     = shf_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        overrun_d = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
        par_d     = par_q;
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.si_valid) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(1);
                    shf_d   = shift_in(shf_q, bus.si);
`ifdef SIPO_DESER_PARITY_EN
                    par_d   = bus.si;
`endif
                end
            end
            SHIFT: begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shf_d   = '0;
`ifdef SIPO_DESER_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else if (bus.si_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    shf_d = shift_in(shf_q, bus.si);
`ifdef SIPO_DESER_PARITY_EN
                    par_d = par_q ^ bus.si;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (o_valid_q && bus.o_ready) o_valid_d = 1'b0;
        // A completed word either takes the free slot or is dropped with an overrun pulse.
        if (last) begin
            if (slot_free) begin
                o_d       = word_d;
                o_valid_d = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
                perr_d    = par_q ^ bus.si;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shf_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shf_q     <= shf_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            busy_q    <= (cnt_d != '0);
            overrun_q <= overrun_d;
`ifdef SIPO_DESER_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.o       = o_q;
    assign bus.o_valid = o_valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
`ifdef SIPO_DESER_PARITY_EN
    assign bus.perr    = perr_q;
`else
    assign bus.perr    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: one MSB-first and one LSB-first instance fed the same stream.
module tb_sipo_deser;
    localparam int W = 7;
`ifdef SIPO_DESER_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    sipo_deser_if #(.WIDTH(W)) m_if ();
    sipo_deser_if #(.WIDTH(W)) l_if ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(m_if.slave));
    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(l_if.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic v);
        m_if.si = b; m_if.si_valid = v;
        l_if.si = b; l_if.si_valid = v;
    endtask

    task automatic set_ready(input logic r);
        m_if.o_ready = r;
        l_if.o_ready = r;
    endtask

    task automatic put(input logic b);
        drive(b, 1'b1);
        tick();
        drive(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic pbit, input logic rdy_last, input int gap_max);
        logic b;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            b = (i < W) ? w[W-1-i] : pbit;
            if (i == N - 1) set_ready(rdy_last);
            put(b);
            if (i == 0)     chk("busy_first", m_if.busy, 1);
            if (i == N - 2) chk("busy_penult", m_if.busy, 1);
        end
        set_ready(1'b0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_o"},       m_if.o, 0);
        chk({tag, "_o_lsb"},   l_if.o, 0);
        chk({tag, "_ovalid"},  m_if.o_valid, 0);
        chk({tag, "_busy"},    m_if.busy, 0);
        chk({tag, "_overrun"}, m_if.overrun, 0);
        chk({tag, "_perr"},    m_if.perr, 0);
    endtask

    initial begin
        drive(1'b0, 1'b0);
        set_ready(1'b0);
        tick();
        tick();
        chk_cleared("rst_hold");
        rst = 1'b0;
        tick();

        // MSB-first word, LSB-first instance sees the bit-reversed word
        send_word(7'b1010011, ^7'b1010011, 1'b0, 0);
        chk("w1_o",       m_if.o, 7'b1010011);
        chk("w1_o_lsb",   l_if.o, 7'b1100101);
        chk("w1_ovalid",  m_if.o_valid, 1);
        chk("w1_busy",    m_if.busy, 0);
        chk("w1_overrun", m_if.overrun, 0);
        chk("w1_perr",    m_if.perr, 0);

        // asynchronous reset mid-cycle with a held word and a partial word
        put(1'b1);
        put(1'b0);
        chk("part_busy", m_if.busy, 1);
        #2 rst = 1'b1;
        #1 chk_cleared("arst");
        #2 rst = 1'b0;
        repeat (5) tick();
        chk_cleared("idle5");

        // same word with random gaps, then a one-edge handshake
        send_word(7'b1010011, ^7'b1010011, 1'b0, 3);
        chk("gap_o",      m_if.o, 7'b1010011);
        chk("gap_ovalid", m_if.o_valid, 1);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        chk("cons_ovalid", m_if.o_valid, 0);
        chk("cons_o",      m_if.o, 7'b1010011);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        chk("idle_rdy_ovalid", m_if.o_valid, 0);

        // backpressure: second word dropped with a single overrun pulse
        send_word(7'b0000111, ^7'b0000111, 1'b0, 0);
        chk("bp1_o", m_if.o, 7'b0000111);
        send_word(7'b1111000, ^7'b1111000, 1'b0, 0);
        chk("bp2_overrun", m_if.overrun, 1);
        chk("bp2_o",       m_if.o, 7'b0000111);
        chk("bp2_ovalid",  m_if.o_valid, 1);
        tick();
        chk("bp2_overrun_end", m_if.overrun, 0);
        send_word(7'b0101010, ^7'b0101010, 1'b1, 0);
        chk("bp3_o",       m_if.o, 7'b0101010);
        chk("bp3_ovalid",  m_if.o_valid, 1);
        chk("bp3_overrun", m_if.overrun, 0);

        // back-to-back words with ready on each final edge
        send_word(7'b1100110, ^7'b1100110, 1'b1, 0);
        chk("b2b1_o",       m_if.o, 7'b1100110);
        chk("b2b1_overrun", m_if.overrun, 0);
        send_word(7'b0011001, ^7'b0011001, 1'b1, 0);
        chk("b2b2_o",       m_if.o, 7'b0011001);
        chk("b2b2_o_lsb",   l_if.o, 7'b1001100);
        chk("b2b2_overrun", m_if.overrun, 0);

        // reset in the middle of a word, then a clean word
        repeat (4) put(1'b1);
        #2 rst = 1'b1;
        #1 chk("mid_busy", m_if.busy, 0);
        #2 rst = 1'b0;
        tick();
        send_word(7'b0000111, ^7'b0000111, 1'b0, 0);
        chk("mid_o",     m_if.o, 7'b0000111);
        chk("mid_o_lsb", l_if.o, 7'b1110000);
        chk("mid_ovalid", m_if.o_valid, 1);

`ifdef SIPO_DESER_PARITY_EN
        send_word(7'b0000111, 1'b1, 1'b1, 0);
        chk("par_good_perr",   m_if.perr, 0);
        chk("par_good_ovalid", m_if.o_valid, 1);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        for (int i = 0; i < W; i++) put(((7'b0000111 >> (W - 1 - i)) & 7'd1) != 0);
        chk("par_7th_ovalid", m_if.o_valid, 0);
        chk("par_7th_busy",   m_if.busy, 1);
        put(1'b0);
        chk("par_bad_ovalid", m_if.o_valid, 1);
        chk("par_bad_perr",   m_if.perr, 1);
        chk("par_bad_o",      m_if.o, 7'b0000111);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
